// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC register, word-addressed instruction memory with a
// program-load port, next-PC selection (jump > branch > halt > stall > +4) and IF_flush.
module if_fetch_stage #(
  parameter int          IMEM_DEPTH = 256,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] HALT_INSN  = 32'hFFFF_FFFF,
  localparam int         ADDR_W     = $clog2(IMEM_DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              PC_write,
  input  logic              branch_taken,
  input  logic [31:0]       branch_target,
  input  logic              jump,
  input  logic [31:0]       jump_target,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [31:0]       prog_data,
  output logic [31:0]       PC_out,
  output logic [31:0]       PC_plus4,
  output logic [31:0]       InsOut,
  output logic              IF_flush,
  output logic              halted,
  output logic [31:0]       fetch_count
);

  typedef enum logic [1:0] {ST_BOOT, ST_RUN, ST_HALT} state_t;

  state_t            state_q, state_d;
  logic [31:0]       pc_q, pc_d;
  logic [31:0]       fetch_count_q, fetch_count_d;
  logic [31:0]       imem [IMEM_DEPTH];

  logic [ADDR_W-1:0] rd_idx;
  logic              in_range;
  logic [31:0]       rd_word;
  logic              run;
  logic              redirect;
  logic              halt_cond;
  logic              advance;

  // Any PC beyond the array reads as a NOP rather than aliasing into low memory.
  assign rd_idx   = pc_q[ADDR_W+1:2];
  assign in_range = (pc_q[31:ADDR_W+2] == '0);
  assign rd_word  = in_range ? imem[rd_idx] : 32'h0;

  assign run       = (state_q == ST_RUN);
  assign redirect  = jump | branch_taken;
  assign InsOut    = run ? rd_word : 32'h0;
  assign IF_flush  = redirect & run;
  assign halt_cond = run & (rd_word == HALT_INSN) & PC_write & ~redirect;
  assign advance   = run & (redirect | (PC_write & ~halt_cond));

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    fetch_count_d = fetch_count_q;
    unique case (state_q)
      ST_BOOT: state_d = ST_RUN;
      ST_RUN: begin
        if (jump)              pc_d = jump_target;
        else if (branch_taken) pc_d = branch_target;
        else if (halt_cond)    state_d = ST_HALT;
        else if (PC_write)     pc_d = pc_q + 32'd4;
        if (advance) fetch_count_d = fetch_count_q + 32'd1;
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_BOOT;
      pc_q          <= RESET_PC;
      fetch_count_q <= 32'h0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  // Program memory is deliberately outside reset so a loaded image survives it.
  always_ff @(posedge clk) begin
    if (prog_we) imem[prog_addr] <= prog_data;
  end

  assign PC_out      = pc_q;
  assign PC_plus4    = pc_q + 32'd4;
  assign halted      = (state_q == ST_HALT);
  assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Scoreboard bench for if_fetch_stage: each cycle's expected outputs are queued
// as stimulus is driven and compared at the following negative clock edge.
module tb_if_fetch_stage;

  typedef struct packed {
    logic        rst;
    logic        pw;
    logic        br;
    logic [31:0] bt;
    logic        jp;
    logic [31:0] jt;
    logic        pwe;
    logic [7:0]  pa;
    logic [31:0] pd;
  } stim_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] ins;
    logic        fl;
    logic        h;
    logic [31:0] fc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        PC_write;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic        prog_we;
  logic [7:0]  prog_addr;
  logic [31:0] prog_data;
  logic [31:0] PC_out;
  logic [31:0] PC_plus4;
  logic [31:0] InsOut;
  logic        IF_flush;
  logic        halted;
  logic [31:0] fetch_count;

  int   tests_run    = 0;
  int   tests_failed = 0;
  exp_t sb_q[$];

  if_fetch_stage dut (
    .clk          (clk),
    .reset        (reset),
    .PC_write     (PC_write),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .jump         (jump),
    .jump_target  (jump_target),
    .prog_we      (prog_we),
    .prog_addr    (prog_addr),
    .prog_data    (prog_data),
    .PC_out       (PC_out),
    .PC_plus4     (PC_plus4),
    .InsOut       (InsOut),
    .IF_flush     (IF_flush),
    .halted       (halted),
    .fetch_count  (fetch_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int i);
    case (i)
      0:       init_word = 32'h11;
      1:       init_word = 32'h22;
      2:       init_word = 32'h33;
      3:       init_word = 32'h44;
      4:       init_word = 32'hFFFF_FFFF;
      default: init_word = 32'h1000_0000 + i;
    endcase
  endfunction

  function automatic stim_t st(input logic rst, input logic pw, input logic br,
                               input logic [31:0] bt, input logic jp, input logic [31:0] jt);
    st = '{rst: rst, pw: pw, br: br, bt: bt, jp: jp, jt: jt, pwe: 1'b0, pa: 8'h0, pd: 32'h0};
  endfunction

  function automatic exp_t ex(input logic [31:0] pc, input logic [31:0] ins, input logic fl,
                              input logic h, input logic [31:0] fc);
    ex = '{pc: pc, pc4: pc + 32'd4, ins: ins, fl: fl, h: h, fc: fc};
  endfunction

  task automatic drive(input stim_t s);
    reset         = s.rst;
    PC_write      = s.pw;
    branch_taken  = s.br;
    branch_target = s.bt;
    jump          = s.jp;
    jump_target   = s.jt;
    prog_we       = s.pwe;
    prog_addr     = s.pa;
    prog_data     = s.pd;
  endtask

  // Load the image while reset is held; memory writes are legal during reset.
  task automatic load_program();
    for (int i = 0; i < 256; i++) begin
      reset     = 1'b1;
      PC_write  = 1'b1;
      prog_we   = 1'b1;
      prog_addr = 8'(i);
      prog_data = init_word(i);
      @(posedge clk); #1;
    end
    prog_we = 1'b0;
  endtask

  task automatic test_reset();
    stim_t s[$];
    exp_t  e[$];
    exp_t  got, want;
    s.push_back(st(1, 1, 0, 0, 0, 0)); e.push_back(ex(32'h0, 32'h0, 0, 0, 0));
    s.push_back(st(0, 1, 0, 0, 0, 0)); e.push_back(ex(32'h0, 32'h0, 0, 0, 0));
    for (int i = 0; i < s.size(); i++) begin
      drive(s[i]);
      sb_q.push_back(e[i]);
      @(negedge clk);
      want = sb_q.pop_front();
      got  = '{PC_out, PC_plus4, InsOut, IF_flush, halted, fetch_count};
      tests_run++;
      if (got !== want) begin
        tests_failed++;
        $display("[TB] FAIL reset[%0d]: got pc=%h pc4=%h ins=%h fl=%b h=%b fc=%0d, want pc=%h pc4=%h ins=%h fl=%b h=%b fc=%0d",
                 i, got.pc, got.pc4, got.ins, got.fl, got.h, got.fc, want.pc, want.pc4, want.ins, want.fl, want.h, want.fc);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_sequential();
    stim_t s[$];
    exp_t  e[$];
    exp_t  got, want;
    s.push_back(st(0, 1, 0, 0, 0, 0));     e.push_back(ex(32'h0,  32'h11, 0, 0, 0));
    s.push_back(st(0, 1, 0, 0, 0, 0));     e.push_back(ex(32'h4,  32'h22, 0, 0, 1));
    s.push_back(st(0, 1, 0, 0, 0, 0));     e.push_back(ex(32'h8,  32'h33, 0, 0, 2));
    s.push_back(st(0, 1, 0, 0, 0, 0));     e.push_back(ex(32'hC,  32'h44, 0, 0, 3));
    // Halt word with a jump present: redirect wins and is counted.
    s.push_back(st(0, 1, 0, 0, 1, 32'h8)); e.push_back(ex(32'h10, 32'hFFFF_FFFF, 1, 0, 4));
    for (int i = 0; i < s.size(); i++) begin
      drive(s[i]);
      sb_q.push_back(e[i]);
      @(negedge clk);
      want = sb_q.pop_front();
      got  = '{PC_out, PC_plus4, InsOut, IF_flush, halted, fetch_count};
      tests_run++;
      if (got !== want) begin
        tests_failed++;
        $display("[TB] FAIL sequential[%0d]: got pc=%h pc4=%h ins=%h fl=%b h=%b fc=%0d, want pc=%h pc4=%h ins=%h fl=%b h=%b fc=%0d",
                 i, got.pc, got.pc4, got.ins, got.fl, got.h, got.fc, want.pc, want.pc4, want.ins, want.fl, want.h, want.fc);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_stall();
    stim_t s[$];
    exp_t  e[$];
    exp_t  got, want;
    s.push_back(st(0, 0, 0, 0, 0, 0)); e.push_back(ex(32'h8, 32'h33, 0, 0, 5));
    s.push_back(st(0, 0, 0, 0, 0, 0)); e.push_back(ex(32'h8, 32'h33, 0, 0, 5));
    s.push_back(st(0, 1, 0, 0, 0, 0)); e.push_back(ex(32'h8, 32'h33, 0, 0, 5));
    s.push_back(st(0, 0, 0, 0, 0, 0)); e.push_back(ex(32'hC, 32'h44, 0, 0, 6));
    for (int i = 0; i < s.size(); i++) begin
      drive(s[i]);
      sb_q.push_back(e[i]);
      @(negedge clk);
      want = sb_q.pop_front();
      got  = '{PC_out, PC_plus4, InsOut, IF_flush, halted, fetch_count};
      tests_run++;
      if (got !== want) begin
        tests_failed++;
        $display("[TB] FAIL stall[%0d]: got pc=%h pc4=%h ins=%h fl=%b h=%b fc=%0d, want pc=%h pc4=%h ins=%h fl=%b h=%b fc=%0d",
                 i, got.pc, got.pc4, got.ins, got.fl, got.h, got.fc, want.pc, want.pc4, want.ins, want.fl, want.h, want.fc);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_branch_stall();
    stim_t s[$];
    exp_t  e[$];
    exp_t  got, want;
    s.push_back(st(0, 0, 0, 0, 1, 32'h4));     e.push_back(ex(32'hC,  32'h44, 1, 0, 6));
    s.push_back(st(0, 0, 1, 32'h40, 0, 0));    e.push_back(ex(32'h4,  32'h22, 1, 0, 7));
    s.push_back(st(0, 1, 0, 0, 0, 0));         e.push_back(ex(32'h40, 32'h1000_0010, 0, 0, 8));
    for (int i = 0; i < s.size(); i++) begin
      drive(s[i]);
      sb_q.push_back(e[i]);
      @(negedge clk);
      want = sb_q.pop_front();
      got  = '{PC_out, PC_plus4, InsOut, IF_flush, halted, fetch_count};
      tests_run++;
      if (got !== want) begin
        tests_failed++;
        $display("[TB] FAIL branch_stall[%0d]: got pc=%h pc4=%h ins=%h fl=%b h=%b fc=%0d, want pc=%h pc4=%h ins=%h fl=%b h=%b fc=%0d",
                 i, got.pc, got.pc4, got.ins, got.fl, got.h, got.fc, want.pc, want.pc4, want.ins, want.fl, want.h, want.fc);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_jump_branch();
    stim_t s[$];
    exp_t  e[$];
    exp_t  got, want;
    s.push_back(st(0, 1, 1, 32'h40, 1, 32'h80)); e.push_back(ex(32'h44, 32'h1000_0011, 1, 0, 9));
    s.push_back(st(0, 0, 0, 0, 0, 0));           e.push_back(ex(32'h80, 32'h1000_0020, 0, 0, 10));
    for (int i = 0; i < s.size(); i++) begin
      drive(s[i]);
      sb_q.push_back(e[i]);
      @(negedge clk);
      want = sb_q.pop_front();
      got  = '{PC_out, PC_plus4, InsOut, IF_flush, halted, fetch_count};
      tests_run++;
      if (got !== want) begin
        tests_failed++;
        $display("[TB] FAIL jump_branch[%0d]: got pc=%h pc4=%h ins=%h fl=%b h=%b fc=%0d, want pc=%h pc4=%h ins=%h fl=%b h=%b fc=%0d",
                 i, got.pc, got.pc4, got.ins, got.fl, got.h, got.fc, want.pc, want.pc4, want.ins, want.fl, want.h, want.fc);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_edges();
    stim_t s[$];
    exp_t  e[$];
    exp_t  got, want;
    s.push_back(st(0, 1, 0, 0, 1, 32'h400));       e.push_back(ex(32'h80, 32'h1000_0020, 1, 0, 10));
    s.push_back(st(0, 1, 0, 0, 0, 0));             e.push_back(ex(32'h400, 32'h0, 0, 0, 11));
    s.push_back(st(0, 1, 0, 0, 1, 32'hFFFF_FFFC)); e.push_back(ex(32'h404, 32'h0, 1, 0, 12));
    s.push_back(st(0, 1, 0, 0, 0, 0));             e.push_back('{pc: 32'hFFFF_FFFC, pc4: 32'h0, ins: 32'h0, fl: 1'b0, h: 1'b0, fc: 32'd13});
    s.push_back(st(0, 0, 0, 0, 0, 0));             e.push_back(ex(32'h0, 32'h11, 0, 0, 14));
    for (int i = 0; i < s.size(); i++) begin
      drive(s[i]);
      sb_q.push_back(e[i]);
      @(negedge clk);
      want = sb_q.pop_front();
      got  = '{PC_out, PC_plus4, InsOut, IF_flush, halted, fetch_count};
      tests_run++;
      if (got !== want) begin
        tests_failed++;
        $display("[TB] FAIL edges[%0d]: got pc=%h pc4=%h ins=%h fl=%b h=%b fc=%0d, want pc=%h pc4=%h ins=%h fl=%b h=%b fc=%0d",
                 i, got.pc, got.pc4, got.ins, got.fl, got.h, got.fc, want.pc, want.pc4, want.ins, want.fl, want.h, want.fc);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_prog_write();
    stim_t s[$];
    exp_t  e[$];
    exp_t  got, want;
    stim_t w;
    w = st(0, 0, 0, 0, 0, 0);
    w.pwe = 1'b1;
    w.pa  = 8'h0;
    w.pd  = 32'hDEAD_BEEF;
    s.push_back(w);                    e.push_back(ex(32'h0, 32'h11, 0, 0, 14));
    s.push_back(st(0, 0, 0, 0, 0, 0)); e.push_back(ex(32'h0, 32'hDEAD_BEEF, 0, 0, 14));
    for (int i = 0; i < s.size(); i++) begin
      drive(s[i]);
      sb_q.push_back(e[i]);
      @(negedge clk);
      want = sb_q.pop_front();
      got  = '{PC_out, PC_plus4, InsOut, IF_flush, halted, fetch_count};
      tests_run++;
      if (got !== want) begin
        tests_failed++;
        $display("[TB] FAIL prog_write[%0d]: got pc=%h pc4=%h ins=%h fl=%b h=%b fc=%0d, want pc=%h pc4=%h ins=%h fl=%b h=%b fc=%0d",
                 i, got.pc, got.pc4, got.ins, got.fl, got.h, got.fc, want.pc, want.pc4, want.ins, want.fl, want.h, want.fc);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_halt();
    stim_t s[$];
    exp_t  e[$];
    exp_t  got, want;
    s.push_back(st(0, 0, 0, 0, 1, 32'h10)); e.push_back(ex(32'h0,  32'hDEAD_BEEF, 1, 0, 14));
    s.push_back(st(0, 1, 0, 0, 0, 0));      e.push_back(ex(32'h10, 32'hFFFF_FFFF, 0, 0, 15));
    s.push_back(st(0, 1, 0, 0, 1, 32'h80)); e.push_back(ex(32'h10, 32'h0, 0, 1, 15));
    s.push_back(st(0, 1, 0, 0, 0, 0));      e.push_back(ex(32'h10, 32'h0, 0, 1, 15));
    s.push_back(st(1, 1, 0, 0, 1, 32'h80)); e.push_back(ex(32'h10, 32'h0, 0, 1, 15));
    s.push_back(st(0, 1, 0, 0, 0, 0));      e.push_back(ex(32'h0,  32'h0, 0, 0, 0));
    s.push_back(st(0, 0, 0, 0, 0, 0));      e.push_back(ex(32'h0,  32'hDEAD_BEEF, 0, 0, 0));
    for (int i = 0; i < s.size(); i++) begin
      drive(s[i]);
      sb_q.push_back(e[i]);
      @(negedge clk);
      want = sb_q.pop_front();
      got  = '{PC_out, PC_plus4, InsOut, IF_flush, halted, fetch_count};
      tests_run++;
      if (got !== want) begin
        tests_failed++;
        $display("[TB] FAIL halt[%0d]: got pc=%h pc4=%h ins=%h fl=%b h=%b fc=%0d, want pc=%h pc4=%h ins=%h fl=%b h=%b fc=%0d",
                 i, got.pc, got.pc4, got.ins, got.fl, got.h, got.fc, want.pc, want.pc4, want.ins, want.fl, want.h, want.fc);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    drive(st(1, 1, 0, 0, 0, 0));
    load_program();
    test_reset();
    test_sequential();
    test_stall();
    test_branch_stall();
    test_jump_branch();
    test_edges();
    test_prog_write();
    test_halt();
    if (sb_q.size() != 0) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending entries, want 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got simulation time %0t, want completion before it", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
Instruction-fetch stage sitting directly upstream of the IF/ID pipeline register. Holds the program counter and a word-addressed instruction memory with a program-load port. Selects the next PC from sequential, branch and jump sources, and honours stalls from hazard logic. Produces PC, PC+4, the fetched instruction and the IF_flush request consumed by IF/ID.

Parameters:
IMEM_DEPTH, 256, number of 32-bit instruction words; power of two, ADDR_W = log2(IMEM_DEPTH)
RESET_PC, 32'h0000_0000, PC value loaded on reset
HALT_INSN, 32'hFFFF_FFFF, instruction encoding that stops fetch

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
PC_write  input  1  1 = PC may advance; 0 = stall (hold PC)
branch_taken  input  1  redirect to branch_target this cycle
branch_target  input  32  branch destination byte address
jump  input  1  redirect to jump_target this cycle
jump_target  input  32  jump destination byte address
prog_we  input  1  instruction-memory write enable
prog_addr  input  ADDR_W  word address for program load
prog_data  input  32  word to write
PC_out  output  32  current PC, feeds IF_ID PC_In
PC_plus4  output  32  PC_out + 4, mod 2^32
InsOut  output  32  fetched instruction, feeds IF_ID InsIn
IF_flush  output  1  squash request to IF_ID
halted  output  1  1 while in HALT state
fetch_count  output  32  number of instructions fetched since reset

Behaviour:
- Reset (synchronous, all state):
  - PC <= RESET_PC; state <= BOOT; fetch_count <= 0.
  - The imem array is NOT cleared.
  - Reset wins over every other input in the same cycle, including mid-halt and mid-stall.
- States and transitions:
  - BOOT -> RUN unconditionally after one cycle.
  - RUN -> HALT on the HALT condition (below).
  - HALT stays in HALT until reset.
- Instruction read:
  - Combinational read at word index PC[ADDR_W+1:2]; PC[1:0] is ignored.
  - PC >= 4*IMEM_DEPTH reads 32'h0 (NOP).
  - InsOut = 32'h0 whenever state != RUN.
- Next PC in RUN, evaluated at each posedge in this priority order:
  - jump: PC <= jump_target.
  - branch_taken: PC <= branch_target.
  - HALT condition: PC holds.
  - PC_write == 0: PC holds.
  - otherwise: PC <= PC + 4, wrapping at 2^32.
  - A redirect overrides a stall. jump and branch_taken together: jump wins.
  - In BOOT and HALT, PC holds and redirects are ignored.
- IF_flush:
  - Combinational: (jump | branch_taken) & (state == RUN).
  - Asserted in the same cycle as the redirect so IF_ID drops the wrong-path word at that edge.
- HALT condition:
  - state == RUN, InsOut == HALT_INSN, PC_write == 1, and no redirect.
  - The next state is HALT. The halt word itself is presented on InsOut for that one cycle.
- halted = (state == HALT), registered.
- fetch_count:
  - Increments by 1 at each edge where state == RUN and the PC advances or redirects.
  - Does not increment on stall, BOOT, HALT, or the halt-detect edge.
  - Wraps at 2^32.
- Program port:
  - prog_we writes prog_data to imem[prog_addr] at posedge; allowed in any state, including during reset.
  - A same-cycle read of the address being written returns the old word. The new word is visible from the next cycle.
- PC_plus4 is always PC_out + 4, including in BOOT and HALT.

Test Plan:
- Load words 0..3 = 32'h11,32'h22,32'h33,32'h44 via prog port, pulse reset, PC_write=1 -> cycle after reset: PC_out=0, InsOut=0 (BOOT); then InsOut 11,22,33,44 with PC_out 0,4,8,C; fetch_count=4 after 4 RUN edges.
- Stall: PC_write=0 for 2 cycles at PC=8 -> PC_out=8 and InsOut=32'h33 held for 3 cycles, fetch_count unchanged, IF_flush=0.
- Branch plus stall: at PC=4 assert branch_taken with branch_target=32'h40 and PC_write=0 -> IF_flush=1 that cycle, next PC_out=32'h40.
- Jump plus branch: jump (jump_target=32'h80) and branch (branch_target=32'h40) same cycle -> next PC_out=32'h80.
- Halt: word at 32'h10 = 32'hFFFF_FFFF -> InsOut=FFFF_FFFF one cycle, then halted=1, InsOut=0, PC_out=32'h10 frozen. A jump while halted is ignored. Reset -> PC_out=0, halted=0.
- Edges: PC=32'h400 with IMEM_DEPTH=256 -> InsOut=0. jump_target=32'hFFFF_FFFC -> PC_plus4=0, following PC_out=0. Same-cycle prog_we to the current word -> old word shown, new word visible the next cycle.
